rx_redundant_frame_merge: RTL
=============================

Name: rx_redundant_frame_merge

Overview:
Receive-side counterpart of the redundant video frame sender. Each video packet is transmitted 1, 3, 5 or 7 times with the same 16-bit sequence number and an incrementing copy index (txid). This block takes the byte stream from rgmii_rx after preamble/SFD removal. It parses the header and stages the pixel payload. On FCS verdict it commits the first good copy of each sequence number to the receive VRAM write port and discards later copies.

Parameters:
HDR_LEN, 42, bytes from destination MAC to start of UDP payload (Eth 14 + IPv4 20 + UDP 8)
ETHERTYPE, 16'h0800, required ethertype at offsets 12-13
BUF_AW, 11, staging buffer address width (2048 bytes)
VRAM_DEPTH, 57600, receive VRAM depth; write address wraps at this value
FCS_TIMEOUT, 8, cycles to wait for the FCS verdict after frame end

Ports:
clk  in  1  125 MHz receive-domain clock
rstb  in  1  synchronous reset, active-low
data  in  8  frame byte; offset 0 is the first destination MAC byte; includes 4 FCS bytes
data_valid  in  1  high for the whole frame; a falling edge marks frame end
data_enable  in  1  byte strobe; a byte is accepted when data_valid && data_enable
data_error  in  1  PHY error; any accepted cycle with this bit high marks the frame bad
fcs_valid  in  1  one-cycle pulse carrying the CRC checker verdict
fcs_ok  in  1  FCS good; sampled when fcs_valid is high
vram_we  out  1  VRAM write strobe
vram_addr  out  20  VRAM write address
vram_din  out  8  VRAM write data
seq_out  out  16  sequence number of the last committed frame
txid_out  out  8  copy index of the last committed frame
frame_done  out  1  one-cycle pulse after the last commit write
busy  out  1  high outside IDLE/HEADER/PAYLOAD
cnt_ok  out  16  committed frames, saturating
cnt_dup  out  16  good frames discarded as duplicates, saturating
cnt_bad  out  16  frames dropped for FCS, ethertype, error, length, overrun or timeout; saturating

Behaviour:
- Reset (rstb=0 at a clk edge): all outputs 0, FSM to IDLE, seq_seen_valid=0. A reset mid-commit aborts the commit and leaves VRAM partially written; no frame_done pulse.
- Payload layout at UDP payload offset p = HDR_LEN: p+0..1 = seq (big-endian); p+2 = txid; p+3..5 = startaddr (low 20 bits used); p+6 onward = pixel bytes, then 4 FCS bytes.
- IDLE: the first accepted byte with data_valid high sets byte_cnt=1 and goes to HEADER.
- HEADER: count accepted bytes; latch ethertype, seq, txid and startaddr at their offsets. Reaching byte p+6 goes to PAYLOAD.
- PAYLOAD: each accepted byte is written to staging buffer[wr_ptr], then wr_ptr+1. If wr_ptr would exceed 2^BUF_AW-1, set the overflow flag and stop writing.
- On the falling edge of data_valid (in HEADER or PAYLOAD), go to CHECK. A frame ending in HEADER is bad and short.
- CHECK: wait for fcs_valid. If it does not arrive within FCS_TIMEOUT cycles, the frame is bad. If fcs_valid arrives in the same cycle as the data_valid fall, it is honoured.
- Decision, with pixel length = wr_ptr-4:
  - bad (cnt_bad+1) if any of: fcs_ok=0, data_error seen, ethertype≠ETHERTYPE, short frame, overflow, or pixel length ≤0.
  - duplicate (cnt_dup+1) if seq_seen_valid && seq==seq_seen.
  - otherwise go to COMMIT and set seq_seen=seq, seq_seen_valid=1.
  - Bad and duplicate frames return to IDLE.
- COMMIT: one byte per cycle. Buffer read latency is 1, so the vram_we stream starts 2 cycles after COMMIT entry.
  - vram_addr starts at startaddr and increments; VRAM_DEPTH-1 wraps to 0. A startaddr ≥ VRAM_DEPTH is first reduced mod VRAM_DEPTH by subtracting once (a value ≥ 2·VRAM_DEPTH is bad).
  - After the last write: frame_done=1 for one cycle, seq_out/txid_out updated, cnt_ok+1, back to IDLE.
- Overrun: data_valid rising while busy marks that frame bad (cnt_bad+1 once, at its data_valid fall). Its bytes are ignored, and the FSM does not enter HEADER mid-frame.
- Counters saturate at 16'hFFFF.
- Sequence wrap 16'hFFFF→0 needs no special case; only equality with the last committed seq is tested.

Test Plan:
- Good frame: seq=5, txid=1, startaddr=100, 10 pixel bytes 0x10..0x19, fcs_ok=1 → ten vram_we writes to addr 100..109 with data 0x10..0x19; frame_done once; seq_out=5; cnt_ok=1.
- Redundancy 3: copies txid=1,2,3 with seq=6, all good → only txid=1 committed; cnt_ok+1, cnt_dup+2, no writes for copies 2 and 3.
- First copy bad: seq=7 copy 1 fcs_ok=0, copy 2 good → copy 2 committed, txid_out=2; cnt_bad+1, cnt_ok+1.
- Wrap: startaddr=57598, 4 pixel bytes → writes to 57598, 57599, 0, 1.
- Timeout/abort: no fcs_valid within 8 cycles → cnt_bad+1, no writes. Separately, rstb=0 for one cycle during COMMIT → vram_we=0 the next cycle, all counters 0, no frame_done.
- Overrun: second frame starts during COMMIT of the first → first commit completes intact; cnt_bad+1 for the second frame; the next frame with a new seq is committed normally.

Source files
------------

// File: rtl/rx_redundant_frame_merge.sv
// Receive-side merge of redundant video frames: parses header, stages payload,
// and commits the first good copy of each sequence number to the VRAM write port.
module rx_redundant_frame_merge #(
    parameter int          HDR_LEN     = 42,
    parameter logic [15:0] ETHERTYPE   = 16'h0800,
    parameter int          BUF_AW      = 11,
    parameter int          VRAM_DEPTH  = 57600,
    parameter int          FCS_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [7:0]  data,
    input  logic        data_valid,
    input  logic        data_enable,
    input  logic        data_error,
    input  logic        fcs_valid,
    input  logic        fcs_ok,
    output logic        vram_we,
    output logic [19:0] vram_addr,
    output logic [7:0]  vram_din,
    output logic [15:0] seq_out,
    output logic [7:0]  txid_out,
    output logic        frame_done,
    output logic        busy,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_dup,
    output logic [15:0] cnt_bad
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_COMMIT  = 3'd4;

    localparam logic [7:0]      OFF_P     = 8'(HDR_LEN);
    localparam logic [19:0]     DEPTH     = 20'(VRAM_DEPTH);
    localparam logic [19:0]     DEPTH2    = 20'(2 * VRAM_DEPTH);
    localparam logic [19:0]     ADDR_LAST = 20'(VRAM_DEPTH - 1);
    localparam logic [7:0]      TMO_LAST  = 8'(FCS_TIMEOUT - 1);
    localparam logic [BUF_AW:0] PTR_FOUR  = (BUF_AW + 1)'(4);

    logic [2:0]        state_q, state_d;
    logic              dv_q;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       etype_q, etype_d;
    logic [15:0]       seq_q, seq_d;
    logic [7:0]        txid_q, txid_d;
    logic [19:0]       start_q, start_d;
    logic              err_q, err_d, short_q, short_d, ovf_q, ovf_d;
    logic [BUF_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              rd_vld_q, rd_vld_d;
    logic [7:0]        rd_data_q;
    logic [19:0]       waddr_q, waddr_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              fcs_got_q, fcs_got_d, fcs_okl_q, fcs_okl_d;
    logic              skip_q, skip_d;
    logic [15:0]       seen_q, seen_d;
    logic              seen_vld_q, seen_vld_d;
    logic              vram_we_q, vram_we_d;
    logic [19:0]       vram_addr_q, vram_addr_d;
    logic [7:0]        vram_din_q, vram_din_d;
    logic [15:0]       seq_out_q, seq_out_d;
    logic [7:0]        txid_out_q, txid_out_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       cnt_ok_q, cnt_ok_d, cnt_dup_q, cnt_dup_d, cnt_bad_q, cnt_bad_d;

    logic [7:0]        stage_mem [2**BUF_AW];
    logic              mem_we;
    logic              accept, dv_rise, dv_fall, busy_w, fcs_now, frame_bad;
    logic [1:0]        bad_inc;
    logic              dup_inc, ok_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + 17'(inc);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        etype_d      = etype_q;
        seq_d        = seq_q;
        txid_d       = txid_q;
        start_d      = start_q;
        err_d        = err_q;
        short_d      = short_q;
        ovf_d        = ovf_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_vld_d     = 1'b0;
        waddr_d      = waddr_q;
        tmo_d        = tmo_q;
        fcs_got_d    = fcs_got_q;
        fcs_okl_d    = fcs_okl_q;
        skip_d       = skip_q;
        seen_d       = seen_q;
        seen_vld_d   = seen_vld_q;
        vram_we_d    = rd_vld_q;
        vram_addr_d  = vram_addr_q;
        vram_din_d   = vram_din_q;
        seq_out_d    = seq_out_q;
        txid_out_d   = txid_out_q;
        frame_done_d = 1'b0;
        mem_we       = 1'b0;
        bad_inc      = 2'd0;
        dup_inc      = 1'b0;
        ok_inc       = 1'b0;

        accept  = data_valid && data_enable;
        dv_rise = data_valid && !dv_q;
        dv_fall = !data_valid && dv_q;
        busy_w  = (state_q == S_CHECK) || (state_q == S_COMMIT);
        fcs_now = fcs_got_q ? fcs_okl_q : fcs_ok;
        frame_bad = !fcs_now || err_q || (etype_q != ETHERTYPE) || short_q || ovf_q
                    || (wr_ptr_q <= PTR_FOUR) || (start_q >= DEPTH2);

        // A frame that starts while busy is ignored entirely and counted bad once at its end.
        if (dv_rise && busy_w) skip_d = 1'b1;
        if (dv_fall && skip_q) begin
            skip_d  = 1'b0;
            bad_inc = bad_inc + 2'd1;
        end

        if (rd_vld_q) begin
            vram_addr_d = waddr_q;
            vram_din_d  = rd_data_q;
            waddr_d     = (waddr_q == ADDR_LAST) ? 20'd0 : waddr_q + 20'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && !skip_q) begin
                    state_d    = S_HEADER;
                    byte_cnt_d = 8'd1;
                    err_d      = data_error;
                    short_d    = 1'b0;
                    ovf_d      = 1'b0;
                    wr_ptr_d   = '0;
                    etype_d    = '0;
                end
            end
            S_HEADER, S_PAYLOAD: begin
                if (dv_fall) begin
                    state_d   = S_CHECK;
                    short_d   = (state_q == S_HEADER);
                    tmo_d     = '0;
                    fcs_got_d = fcs_valid;
                    fcs_okl_d = fcs_ok;
                end else if (accept) begin
                    err_d = err_q | data_error;
                    if (state_q == S_HEADER) begin
                        if (byte_cnt_q == 8'd12)         etype_d[15:8]  = data;
                        if (byte_cnt_q == 8'd13)         etype_d[7:0]   = data;
                        if (byte_cnt_q == OFF_P)         seq_d[15:8]    = data;
                        if (byte_cnt_q == OFF_P + 8'd1)  seq_d[7:0]     = data;
                        if (byte_cnt_q == OFF_P + 8'd2)  txid_d         = data;
                        if (byte_cnt_q == OFF_P + 8'd3)  start_d[19:16] = data[3:0];
                        if (byte_cnt_q == OFF_P + 8'd4)  start_d[15:8]  = data;
                        if (byte_cnt_q == OFF_P + 8'd5) begin
                            start_d[7:0] = data;
                            state_d      = S_PAYLOAD;
                        end
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end else if (!wr_ptr_q[BUF_AW]) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (fcs_got_q || fcs_valid) begin
                    if (frame_bad) begin
                        bad_inc = bad_inc + 2'd1;
                        state_d = S_IDLE;
                    end else if (seen_vld_q && (seq_q == seen_q)) begin
                        dup_inc = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_COMMIT;
                        seen_d     = seq_q;
                        seen_vld_d = 1'b1;
                        rd_ptr_d   = '0;
                        waddr_d    = (start_q >= DEPTH) ? start_q - DEPTH : start_q;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    bad_inc = bad_inc + 2'd1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_COMMIT: begin
                // Reads run one stage ahead of the VRAM write register; finish once both drain.
                if (rd_ptr_q != wr_ptr_q - PTR_FOUR) begin
                    rd_vld_d = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end else if (!rd_vld_q && vram_we_q) begin
                    frame_done_d = 1'b1;
                    seq_out_d    = seq_q;
                    txid_out_d   = txid_q;
                    ok_inc       = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cnt_ok_d  = sat_add(cnt_ok_q, {1'b0, ok_inc});
        cnt_dup_d = sat_add(cnt_dup_q, {1'b0, dup_inc});
        cnt_bad_d = sat_add(cnt_bad_q, bad_inc);
    end

    always_ff @(posedge clk) begin
        if (mem_we) stage_mem[wr_ptr_q[BUF_AW-1:0]] <= data;
        rd_data_q <= stage_mem[rd_ptr_q[BUF_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= S_IDLE;   dv_q <= 1'b0;      byte_cnt_q <= '0;
            etype_q <= '0;       seq_q <= '0;       txid_q <= '0;      start_q <= '0;
            err_q <= 1'b0;       short_q <= 1'b0;   ovf_q <= 1'b0;
            wr_ptr_q <= '0;      rd_ptr_q <= '0;    rd_vld_q <= 1'b0;  waddr_q <= '0;
            tmo_q <= '0;         fcs_got_q <= 1'b0; fcs_okl_q <= 1'b0; skip_q <= 1'b0;
            seen_q <= '0;        seen_vld_q <= 1'b0;
            vram_we_q <= 1'b0;   vram_addr_q <= '0; vram_din_q <= '0;
            seq_out_q <= '0;     txid_out_q <= '0;  frame_done_q <= 1'b0;
            cnt_ok_q <= '0;      cnt_dup_q <= '0;   cnt_bad_q <= '0;
        end else begin
            state_q <= state_d;  dv_q <= data_valid; byte_cnt_q <= byte_cnt_d;
            etype_q <= etype_d;  seq_q <= seq_d;     txid_q <= txid_d;   start_q <= start_d;
            err_q <= err_d;      short_q <= short_d; ovf_q <= ovf_d;
            wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; rd_vld_q <= rd_vld_d; waddr_q <= waddr_d;
            tmo_q <= tmo_d;      fcs_got_q <= fcs_got_d; fcs_okl_q <= fcs_okl_d; skip_q <= skip_d;
            seen_q <= seen_d;    seen_vld_q <= seen_vld_d;
            vram_we_q <= vram_we_d; vram_addr_q <= vram_addr_d; vram_din_q <= vram_din_d;
            seq_out_q <= seq_out_d; txid_out_q <= txid_out_d; frame_done_q <= frame_done_d;
            cnt_ok_q <= cnt_ok_d; cnt_dup_q <= cnt_dup_d; cnt_bad_q <= cnt_bad_d;
        end
    end

    assign vram_we    = vram_we_q;
    assign vram_addr  = vram_addr_q;
    assign vram_din   = vram_din_q;
    assign seq_out    = seq_out_q;
    assign txid_out   = txid_out_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_w;
    assign cnt_ok     = cnt_ok_q;
    assign cnt_dup    = cnt_dup_q;
    assign cnt_bad    = cnt_bad_q;

endmodule
